dense_0_ctrl: RTL

Sequencer for the first dense layer of the CNN accelerator. It walks the dense weight ROM (`memory_dens_0`, 1-cycle read latency) and the flattened feature-map buffer in lockstep. It drives the clear, enable and last strobes of the downstream MAC and hands each finished neuron result out over a valid/ready handshake. One `start` pulse runs a complete layer pass of NUM_OUT neurons × NUM_IN inputs.

---
 rtl/dense_ctrl_pkg.sv | 16 +
 rtl/dense_addr_gen.sv | 44 ++++
 rtl/dense_0_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/dense_ctrl_pkg.sv
// Shared constants and FSM encoding for the first dense-layer sequencer,
// sized to match memory_dens_0 (NUM_IN*NUM_OUT = 507 words) and the MAC.
package dense_ctrl_pkg;
  localparam int D_NUM_IN    = 169;
  localparam int D_NUM_OUT   = 3;
  localparam int D_ADDR_W    = 10;
  localparam int D_IN_ADDR_W = 8;
  localparam int D_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/dense_addr_gen.sv
// Input/neuron/weight-address counters for the dense sequencer.
// w_addr free-runs across neurons so no n*NUM_IN multiply is needed.
module dense_addr_gen
  import dense_ctrl_pkg::*;
#(
  parameter int NUM_IN    = D_NUM_IN,
  parameter int NUM_OUT   = D_NUM_OUT,
  parameter int ADDR_W    = D_ADDR_W,
  parameter int IN_ADDR_W = D_IN_ADDR_W,
  parameter int IDX_W     = D_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 next,
  output logic [ADDR_W-1:0]    w_addr,
  output logic [IN_ADDR_W-1:0] i,
  output logic [IDX_W-1:0]     n,
  output logic                 last_in,
  output logic                 last_out
);
  assign last_in  = (i == IN_ADDR_W'(NUM_IN - 1));
  assign last_out = (n == IDX_W'(NUM_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr <= '0;
      i      <= '0;
      n      <= '0;
    end else if (clr) begin
      w_addr <= '0;
      i      <= '0;
      n      <= '0;
    end else begin
      // i wraps on the last term so the next neuron starts at x_addr 0
      if (inc) begin
        w_addr <= w_addr + 1'b1;
        i      <= last_in ? '0 : i + 1'b1;
      end
      if (next) n <= n + 1'b1;
    end
  end
endmodule

// File: rtl/dense_0_ctrl.sv
// Dense layer 0 sequencer: walks weight ROM and feature buffer in lockstep,
// drives MAC strobes one stage behind the reads, and hands results out.
module dense_0_ctrl
  import dense_ctrl_pkg::*;
#(
  parameter int NUM_IN    = D_NUM_IN,
  parameter int NUM_OUT   = D_NUM_OUT,
  parameter int ADDR_W    = D_ADDR_W,
  parameter int IN_ADDR_W = D_IN_ADDR_W,
  parameter int IDX_W     = D_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 w_en,
  output logic [ADDR_W-1:0]    w_addr,
  output logic                 x_en,
  output logic [IN_ADDR_W-1:0] x_addr,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic                 mac_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx
);
  state_t               state;
  logic [IN_ADDR_W-1:0] i;
  logic [IDX_W-1:0]     n;
  logic                 last_in, last_out;
  logic                 cnt_clr, cnt_inc, cnt_next;

  assign cnt_clr  = (state == IDLE) && start;
  assign cnt_inc  = (state == RUN);
  assign cnt_next = (state == OUT) && out_ready && !last_out;

  dense_addr_gen #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W),
    .IN_ADDR_W(IN_ADDR_W), .IDX_W(IDX_W)
  ) u_addr (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc), .next(cnt_next),
    .w_addr(w_addr), .i(i), .n(n), .last_in(last_in), .last_out(last_out)
  );

  assign x_en    = w_en;
  assign x_addr  = i;
  assign out_idx = n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      w_en      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          w_en  <= 1'b1;
        end
        RUN: if (last_in) begin
          state <= WAIT;
          w_en  <= 1'b0;
        end
        // last term's ROM data is on the bus this cycle; result follows
        WAIT: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (last_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            w_en  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // one stage behind the issue so the strobes line up with ROM read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
    end else begin
      mac_en   <= w_en;
      mac_clr  <= w_en && (i == '0);
      mac_last <= w_en && last_in;
    end
  end
endmodule
